// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, widths, flag positions and FSM states for the ALU sequencer
package alu_pkg;

    localparam int W    = 4;
    localparam int RIDX = 2;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_NOT = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_OR  = 3'b100;
    localparam logic [2:0] ALU_XOR = 3'b101;
    localparam logic [2:0] ALU_LT  = 3'b110;
    localparam logic [2:0] ALU_EQ  = 3'b111;

    // Bit positions inside the 3-bit {zero, overflow, carry} flag word
    localparam int FLAG_Z  = 2;
    localparam int FLAG_OV = 1;
    localparam int FLAG_C  = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_regfile_4x4.sv
// rtl/alu_regfile_4x4.sv - register file: 2 operand read ports, 1 debug read port, 1 write port
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset (all registers to 0)
//   i_we/i_waddr/i_wdata     synchronous write port
//   i_raddr_a -> o_rdata_a   combinational operand A read
//   i_raddr_b -> o_rdata_b   combinational operand B read
//   i_dbg_sel -> o_dbg_data  combinational debug read
module alu_regfile_4x4 #(
    parameter int NREG = 4,
    parameter int W    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_we,
    input  logic [$clog2(NREG)-1:0] i_waddr,
    input  logic [W-1:0]            i_wdata,
    input  logic [$clog2(NREG)-1:0] i_raddr_a,
    output logic [W-1:0]            o_rdata_a,
    input  logic [$clog2(NREG)-1:0] i_raddr_b,
    output logic [W-1:0]            o_rdata_b,
    input  logic [$clog2(NREG)-1:0] i_dbg_sel,
    output logic [W-1:0]            o_dbg_data
);

    logic [W-1:0] r_regs [NREG];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a  = r_regs[i_raddr_a];
    assign o_rdata_b  = r_regs[i_raddr_b];
    assign o_dbg_data = r_regs[i_dbg_sel];

endmodule

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - command-driven front end for the combinational 4-bit ALU
//
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   cmd_valid/cmd_ready               command handshake
//   cmd_ld/op/rd/rs1/rs2/imm          command fields (load immediate or ALU op)
//   alu_fnselec/alu_a/alu_b           registered ALU inputs
//   alu_res/zero/overflow/carry       ALU outputs, captured at the end of EXEC
//   rsp_valid/rsp_ready               response handshake
//   rsp_res, rsp_flags                written value and {zero, overflow, carry}
//   dbg_sel -> dbg_data               combinational register read-back
module alu_cmd_sequencer #(
    parameter int NREG = 4,
    parameter int W    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_ld,
    input  logic [2:0]              cmd_op,
    input  logic [$clog2(NREG)-1:0] cmd_rd,
    input  logic [$clog2(NREG)-1:0] cmd_rs1,
    input  logic [$clog2(NREG)-1:0] cmd_rs2,
    input  logic [W-1:0]            cmd_imm,
    output logic [2:0]              alu_fnselec,
    output logic [W-1:0]            alu_a,
    output logic [W-1:0]            alu_b,
    input  logic [W-1:0]            alu_res,
    input  logic                    alu_zero,
    input  logic                    alu_overflow,
    input  logic                    alu_carry,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [W-1:0]            rsp_res,
    output logic [2:0]              rsp_flags,
    input  logic [$clog2(NREG)-1:0] dbg_sel,
    output logic [W-1:0]            dbg_data
);

    import alu_pkg::*;

    localparam int RW = $clog2(NREG);

    state_t          r_state;
    state_t          w_next_state;
    logic            w_cmd_fire;
    logic            w_we;
    logic [RW-1:0]   w_waddr;
    logic [W-1:0]    w_wdata;
    logic [W-1:0]    w_rdata_a;
    logic [W-1:0]    w_rdata_b;
    logic [2:0]      w_alu_flags;

    logic [2:0]      r_alu_fnselec;
    logic [W-1:0]    r_alu_a;
    logic [W-1:0]    r_alu_b;
    logic [RW-1:0]   r_rd;
    logic [W-1:0]    r_rsp_res;
    logic [2:0]      r_flags;

    alu_regfile_4x4 #(
        .NREG (NREG),
        .W    (W)
    ) u_regfile (
        .clk        (clk),
        .rst        (rst),
        .i_we       (w_we),
        .i_waddr    (w_waddr),
        .i_wdata    (w_wdata),
        .i_raddr_a  (cmd_rs1),
        .o_rdata_a  (w_rdata_a),
        .i_raddr_b  (cmd_rs2),
        .o_rdata_b  (w_rdata_b),
        .i_dbg_sel  (dbg_sel),
        .o_dbg_data (dbg_data)
    );

    always_comb begin
        w_alu_flags          = '0;
        w_alu_flags[FLAG_Z]  = alu_zero;
        w_alu_flags[FLAG_OV] = alu_overflow;
        w_alu_flags[FLAG_C]  = alu_carry;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Write-back happens either on a load accept in IDLE or unconditionally
    // at the end of the EXEC settle cycle; the two never coincide.
    always_comb begin
        w_next_state = r_state;
        w_cmd_fire   = 1'b0;
        w_we         = 1'b0;
        w_waddr      = cmd_rd;
        w_wdata      = cmd_imm;
        case (r_state)
            IDLE: begin
                if (cmd_valid) begin
                    w_cmd_fire = 1'b1;
                    if (cmd_ld) begin
                        w_we         = 1'b1;
                        w_next_state = RESP;
                    end else begin
                        w_next_state = EXEC;
                    end
                end
            end
            EXEC: begin
                w_we         = 1'b1;
                w_waddr      = r_rd;
                w_wdata      = alu_res;
                w_next_state = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Operands are captured at accept, so rd may alias rs1/rs2 safely.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alu_fnselec <= '0;
            r_alu_a       <= '0;
            r_alu_b       <= '0;
            r_rd          <= '0;
            r_rsp_res     <= '0;
            r_flags       <= '0;
        end else begin
            if (w_cmd_fire) begin
                if (cmd_ld) begin
                    r_rsp_res <= cmd_imm;
                end else begin
                    r_alu_fnselec <= cmd_op;
                    r_alu_a       <= w_rdata_a;
                    r_alu_b       <= w_rdata_b;
                    r_rd          <= cmd_rd;
                end
            end
            if (r_state == EXEC) begin
                r_rsp_res <= alu_res;
                r_flags   <= w_alu_flags;
            end
        end
    end

    assign cmd_ready   = (r_state == IDLE);
    assign rsp_valid   = (r_state == RESP);
    assign rsp_res     = r_rsp_res;
    assign rsp_flags   = r_flags;
    assign alu_fnselec = r_alu_fnselec;
    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - directed self-checking bench for alu_cmd_sequencer
module tb_alu_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_ld;
    logic [2:0] cmd_op;
    logic [1:0] cmd_rd;
    logic [1:0] cmd_rs1;
    logic [1:0] cmd_rs2;
    logic [3:0] cmd_imm;
    logic [2:0] alu_fnselec;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [3:0] alu_res;
    logic       alu_zero;
    logic       alu_overflow;
    logic       alu_carry;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_res;
    logic [2:0] rsp_flags;
    logic [1:0] dbg_sel;
    logic [3:0] dbg_data;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [3:0] exp_regs [4];
    logic [2:0] exp_flags;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_cmd_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_ld       (cmd_ld),
        .cmd_op       (cmd_op),
        .cmd_rd       (cmd_rd),
        .cmd_rs1      (cmd_rs1),
        .cmd_rs2      (cmd_rs2),
        .cmd_imm      (cmd_imm),
        .alu_fnselec  (alu_fnselec),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_res      (alu_res),
        .alu_zero     (alu_zero),
        .alu_overflow (alu_overflow),
        .alu_carry    (alu_carry),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_res      (rsp_res),
        .rsp_flags    (rsp_flags),
        .dbg_sel      (dbg_sel),
        .dbg_data     (dbg_data)
    );

    // Behavioural ALU: returns {res[3:0], zero, overflow, carry}
    function automatic logic [6:0] alu_ref(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        logic [4:0] s;
        logic [3:0] r;
        logic       ov;
        logic       c;
        ov = 1'b0;
        c  = 1'b0;
        r  = 4'h0;
        case (op)
            3'b000: begin
                s  = {1'b0, a} + {1'b0, b};
                r  = s[3:0];
                c  = s[4];
                ov = (a[3] == b[3]) && (r[3] != a[3]);
            end
            3'b001: begin
                r  = a - b;
                c  = (a < b);
                ov = (a[3] != b[3]) && (r[3] != a[3]);
            end
            3'b010: r = ~a;
            3'b011: r = a & b;
            3'b100: r = a | b;
            3'b101: r = a ^ b;
            3'b110: r = (a < b) ? 4'h1 : 4'h0;
            default: r = (a == b) ? 4'h1 : 4'h0;
        endcase
        return {r, (r == 4'h0), ov, c};
    endfunction

    logic [6:0] w_model;
    assign w_model      = alu_ref(alu_fnselec, alu_a, alu_b);
    assign alu_res      = w_model[6:3];
    assign alu_zero     = w_model[2];
    assign alu_overflow = w_model[1];
    assign alu_carry    = w_model[0];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 4; i++) begin
            dbg_sel = 2'(i);
            #1;
            check($sformatf("%s_r%0d", tag, i), dbg_data, exp_regs[i]);
        end
    endtask

    // Present a command at a negedge, accept on the next edge, then count
    // edges (including the accept edge) until rsp_valid appears.
    task automatic issue(input logic ld, input logic [2:0] op, input logic [1:0] rd,
                         input logic [1:0] rs1, input logic [1:0] rs2, input logic [3:0] imm,
                         output int lat);
        int n;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("issue_ready", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_ld    = ld;
        cmd_op    = op;
        cmd_rd    = rd;
        cmd_rs1   = rs1;
        cmd_rs2   = rs2;
        cmd_imm   = imm;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic take_rsp(input string tag);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, "_rsp_drop"}, rsp_valid, 0);
        check({tag, "_ready_back"}, cmd_ready, 1);
    endtask

    task automatic run_cmd(input string tag, input logic ld, input logic [2:0] op, input logic [1:0] rd,
                           input logic [1:0] rs1, input logic [1:0] rs2, input logic [3:0] imm);
        logic [6:0] m;
        logic [3:0] res;
        int lat;
        if (ld) begin
            res = imm;
        end else begin
            m   = alu_ref(op, exp_regs[rs1], exp_regs[rs2]);
            res = m[6:3];
            exp_flags = m[2:0];
        end
        issue(ld, op, rd, rs1, rs2, imm, lat);
        check({tag, "_lat"}, lat, ld ? 1 : 2);
        check({tag, "_res"}, rsp_res, res);
        check({tag, "_flags"}, rsp_flags, exp_flags);
        exp_regs[rd] = res;
        take_rsp(tag);
        dbg_sel = rd;
        #1;
        check({tag, "_wb"}, dbg_data, res);
    endtask

    initial begin
        int lat;
        int t_prev;
        int t_acc;
        logic [6:0] m;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_ld    = 1'b0;
        cmd_op    = 3'b000;
        cmd_rd    = 2'd0;
        cmd_rs1   = 2'd0;
        cmd_rs2   = 2'd0;
        cmd_imm   = 4'h0;
        rsp_ready = 1'b0;
        dbg_sel   = 2'd0;
        t_prev    = 0;
        for (int i = 0; i < 4; i++) exp_regs[i] = 4'h0;
        exp_flags = 3'b000;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check_regs("reset");
        check("reset_cmd_ready", cmd_ready, 1);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_flags", rsp_flags, 3'b000);
        check("reset_alu_a", alu_a, 4'h0);

        run_cmd("ld_r0", 1'b1, 3'b000, 2'd0, 2'd0, 2'd0, 4'h9);
        run_cmd("ld_r1", 1'b1, 3'b000, 2'd1, 2'd0, 2'd0, 4'h8);
        run_cmd("add", 1'b0, 3'b000, 2'd2, 2'd0, 2'd1, 4'h0);
        check("add_hand_flags", rsp_flags, 3'b011);
        check("add_hand_res", rsp_res, 4'h1);
        run_cmd("sub", 1'b0, 3'b001, 2'd3, 2'd1, 2'd1, 4'h0);
        check("sub_hand_flags", rsp_flags, 3'b100);
        check("sub_hand_res", rsp_res, 4'h0);
        run_cmd("eq_alias", 1'b0, 3'b111, 2'd0, 2'd0, 2'd0, 4'h0);
        dbg_sel = 2'd0;
        #1;
        check("eq_hand_r0", dbg_data, 4'h1);

        // XOR r1 = r0 ^ r1 = 1 ^ 8 = 9, response held off for 5 cycles
        issue(1'b0, 3'b101, 2'd1, 2'd0, 2'd1, 4'h0, lat);
        check("hold_lat", lat, 2);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("hold_valid_%0d", k), rsp_valid, 1);
            check($sformatf("hold_res_%0d", k), rsp_res, 4'h9);
            check($sformatf("hold_flags_%0d", k), rsp_flags, 3'b000);
            check($sformatf("hold_cmd_ready_%0d", k), cmd_ready, 0);
            cmd_valid = (k == 2);
            cmd_ld    = 1'b1;
            cmd_rd    = 2'd3;
            cmd_imm   = 4'hF;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        exp_regs[1] = 4'h9;
        exp_flags   = 3'b000;
        take_rsp("hold");
        check_regs("hold");

        // Reset in EXEC of ADD r2 = r0 + r1
        cmd_valid = 1'b1;
        cmd_ld    = 1'b0;
        cmd_op    = 3'b000;
        cmd_rd    = 2'd2;
        cmd_rs1   = 2'd0;
        cmd_rs2   = 2'd1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("exec_cmd_ready", cmd_ready, 0);
        check("exec_rsp_valid", rsp_valid, 0);
        rst = 1'b1;
        #1;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) exp_regs[i] = 4'h0;
        exp_flags = 3'b000;
        repeat (2) begin
            @(negedge clk);
            check("post_rst_rsp_valid", rsp_valid, 0);
        end
        check("post_rst_alu_a", alu_a, 4'h0);
        check("post_rst_flags", rsp_flags, 3'b000);
        check_regs("post_rst");

        for (int i = 0; i < 4; i++) begin
            run_cmd($sformatf("rnd_ld%0d", i), 1'b1, 3'b000, 2'(i), 2'd0, 2'd0, 4'($urandom_range(0, 15)));
        end

        // Back-to-back stream with valid/ready tied high
        rsp_ready = 1'b1;
        cmd_valid = 1'b1;
        cmd_ld    = 1'b0;
        for (int k = 0; k < 16; k++) begin
            int n;
            n = 0;
            while (!cmd_ready && n < 10) begin
                @(negedge clk);
                n++;
            end
            check("b2b_ready", cmd_ready, 1);
            cmd_op  = 3'(k % 8);
            cmd_rd  = 2'($urandom_range(0, 3));
            cmd_rs1 = 2'($urandom_range(0, 3));
            cmd_rs2 = 2'($urandom_range(0, 3));
            m = alu_ref(cmd_op, exp_regs[cmd_rs1], exp_regs[cmd_rs2]);
            t_acc = cyc;
            if (k > 0) check($sformatf("b2b_interval_%0d", k), t_acc - t_prev, 3);
            t_prev = t_acc;
            @(negedge clk);
            @(negedge clk);
            check($sformatf("b2b_valid_op%0d", k % 8), rsp_valid, 1);
            check($sformatf("b2b_res_op%0d", k % 8), rsp_res, m[6:3]);
            check($sformatf("b2b_flags_op%0d", k % 8), rsp_flags, m[2:0]);
            exp_regs[cmd_rd] = m[6:3];
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        @(negedge clk);
        check_regs("b2b_end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
